// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: sample delay line, coefficient memory and tap sequencer for a single-multiplier direct-form FIR.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   din        input sample (signed), accepted when val_in=1 and ready=1
//   val_in     din valid strobe
//   ready      high when a sample can be accepted
//   coef_we    coefficient write enable (honoured in IDLE only, coef_addr < Num_coef)
//   coef_addr  coefficient index, 0 = newest-sample tap
//   coef_wdata coefficient value (signed)
//   mac_din    sample to the MAC
//   mac_coef   coefficient to the MAC
//   mac_ce     MAC accumulate enable
//   mac_clr    MAC accumulator clear, active-high
//   mac_dout   MAC accumulator value
//   dout       captured filter output (signed), held until the next capture
//   val_out    one-cycle dout valid strobe
//   ovf        sticky flag: a sample arrived while busy and was dropped
module fir_tap_sequencer #(
    parameter int Win      = 16,
    parameter int Wc       = 18,
    parameter int Num_coef = 17,
    parameter int Wa       = 5,
    parameter int MAC_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [Win-1:0]       din,
    input  logic                        val_in,
    output logic                        ready,
    input  logic                        coef_we,
    input  logic [Wa-1:0]               coef_addr,
    input  logic signed [Wc-1:0]        coef_wdata,
    output logic signed [Win-1:0]       mac_din,
    output logic signed [Wc-1:0]        mac_coef,
    output logic                        mac_ce,
    output logic                        mac_clr,
    input  logic signed [Win+Wc-1:0]    mac_dout,
    output logic signed [Win+Wc-1:0]    dout,
    output logic                        val_out,
    output logic                        ovf
);
    // MAC_LAT must be at least 1; the drain counter runs 0..MAC_LAT-1
    localparam int Wd = MAC_LAT > 1 ? $clog2(MAC_LAT) : 1;
    localparam logic [Wa-1:0] LAST  = Wa'(Num_coef - 1);
    localparam logic [Wa:0]   NC    = (Wa + 1)'(Num_coef);
    localparam logic [Wd-1:0] DLAST = Wd'(MAC_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                  state, state_n;
    logic [Wa-1:0]           wp, wp_n, rp, rp_n, k, k_n;
    logic [Wd-1:0]           d, d_n;
    logic signed [Win-1:0]   dline [Num_coef];
    logic signed [Wc-1:0]    cmem [Num_coef];
    logic signed [Win-1:0]   mac_din_n;
    logic signed [Wc-1:0]    mac_coef_n;
    logic signed [Win+Wc-1:0] dout_n;
    logic                    accept, cwr;

    assign accept = state == IDLE && val_in;
    assign cwr    = state == IDLE && coef_we && {1'b0, coef_addr} < NC;

    always_comb begin
        state_n    = state;
        wp_n       = wp;
        rp_n       = rp;
        k_n        = k;
        d_n        = d;
        mac_din_n  = mac_din;
        mac_coef_n = mac_coef;
        dout_n     = dout;
        case (state)
            IDLE: if (val_in) begin
                state_n    = RUN;
                k_n        = '0;
                rp_n       = wp == '0 ? LAST : wp - 1'b1;
                // tap 0 is the sample and coefficient being written this very edge
                mac_din_n  = din;
                mac_coef_n = cwr && coef_addr == '0 ? coef_wdata : cmem[0];
            end
            RUN: if (k == LAST) begin
                state_n = DRAIN;
                d_n     = '0;
            end else begin
                k_n        = k + 1'b1;
                rp_n       = rp == '0 ? LAST : rp - 1'b1;
                mac_din_n  = dline[rp];
                mac_coef_n = cmem[k_n];
            end
            DRAIN: if (d == DLAST) begin
                state_n = OUT;
                dout_n  = mac_dout;
                wp_n    = wp == LAST ? '0 : wp + 1'b1;
            end else begin
                d_n = d + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wp       <= '0;
            rp       <= '0;
            k        <= '0;
            d        <= '0;
            mac_din  <= '0;
            mac_coef <= '0;
            dout     <= '0;
            ready    <= 1'b1;
            mac_ce   <= 1'b0;
            mac_clr  <= 1'b1;
            val_out  <= 1'b0;
            ovf      <= 1'b0;
            for (int i = 0; i < Num_coef; i++) begin
                dline[i] <= '0;
                cmem[i]  <= '0;
            end
        end else begin
            state    <= state_n;
            wp       <= wp_n;
            rp       <= rp_n;
            k        <= k_n;
            d        <= d_n;
            mac_din  <= mac_din_n;
            mac_coef <= mac_coef_n;
            dout     <= dout_n;
            // control outputs are registered decodes of the state being entered
            ready    <= state_n == IDLE;
            mac_ce   <= state_n == RUN;
            mac_clr  <= state_n == IDLE || state_n == OUT;
            val_out  <= state_n == OUT;
            if (val_in && state != IDLE) ovf <= 1'b1;
            if (accept) dline[wp] <= din;
            if (cwr) cmem[coef_addr] <= coef_wdata;
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: closed-loop bench with a behavioural MAC and a sum-of-products reference model.
module tb_fir_tap_sequencer;
    localparam int N = 17;

    logic clk = 1'b0, rst = 1'b1, val_in = 1'b0, coef_we = 1'b0;
    logic signed [15:0] din = '0;
    logic [4:0] coef_addr = '0;
    logic signed [17:0] coef_wdata = '0;
    logic ready, mac_ce, mac_clr, val_out, ovf;
    logic signed [15:0] mac_din;
    logic signed [17:0] mac_coef;
    logic signed [33:0] mac_dout, dout;
    logic signed [33:0] acc = '0;
    int pass_cnt = 0, total_cnt = 0, vo_cnt = 0;
    longint mc [N];
    longint hist [$];

    fir_tap_sequencer dut (
        .clk(clk), .rst(rst), .din(din), .val_in(val_in), .ready(ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .mac_din(mac_din), .mac_coef(mac_coef), .mac_ce(mac_ce), .mac_clr(mac_clr),
        .mac_dout(mac_dout), .dout(dout), .val_out(val_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // MULT_ACC stand-in: one-cycle registered accumulator
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else if (mac_ce) acc <= acc + 34'(mac_din) * 34'(mac_coef);
    end
    assign mac_dout = acc;

    always @(posedge clk) if (val_out) vo_cnt++;

    // output = sum over taps of coef[k] * (k-th most recent sample since reset), wrapped to 34 bits
    function automatic logic signed [33:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) if (k < hist.size()) s += mc[k] * hist[k];
        return 34'(s);
    endfunction

    task automatic clear_model();
        hist.delete();
        for (int i = 0; i < N; i++) mc[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        val_in = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coef(input int a, input longint v);
        coef_addr = 5'(a);
        coef_wdata = 18'(v);
        coef_we = 1'b1;
        @(posedge clk);
        #1 coef_we = 1'b0;
        if (a < N) mc[a] = v;
    endtask

    task automatic run_sample(input logic signed [15:0] x, output logic signed [33:0] got, output bit to);
        din = x;
        val_in = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        hist.push_front(longint'(x));
        to = 1'b1;
        got = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (val_out) begin
                got = dout;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({ready, mac_clr, mac_ce, val_out, ovf} !== 5'b11000)
            $display("FAIL reset_ctrl got=%b expected=11000", {ready, mac_clr, mac_ce, val_out, ovf});
        else pass_cnt++;
        total_cnt++;
        if (dout !== 34'sd0) $display("FAIL reset_dout got=%0d expected=0", dout);
        else pass_cnt++;
        total_cnt++;
        if ({mac_din, mac_coef} !== 34'd0) $display("FAIL reset_mac got=%0d/%0d expected=0/0", mac_din, mac_coef);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        total_cnt++;
        if ({ready, mac_clr, mac_ce} !== 3'b110) $display("FAIL reset_release got=%b expected=110", {ready, mac_clr, mac_ce});
        else pass_cnt++;
    endtask

    task automatic test_impulse(input string tag);
        logic signed [33:0] got, exp;
        bit to;
        int v0;
        for (int k = 0; k < N; k++) wr_coef(k, k + 1);
        v0 = vo_cnt;
        for (int j = 0; j < 21; j++) begin
            run_sample(j == 0 ? 16'sd1 : 16'sd0, got, to);
            exp = model_out();
            total_cnt++;
            if (to || got !== exp) $display("FAIL %s[%0d] dout=%0d expected=%0d timeout=%0b", tag, j, got, exp, to);
            else pass_cnt++;
        end
        total_cnt++;
        if (vo_cnt - v0 != 21) $display("FAIL %s_valcount got=%0d expected=21", tag, vo_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_step();
        logic signed [33:0] got, exp;
        bit to;
        for (int k = 0; k < N; k++) wr_coef(k, 1);
        for (int j = 0; j < 20; j++) begin
            run_sample(16'sd1, got, to);
            exp = model_out();
            total_cnt++;
            if (to || got !== exp) $display("FAIL step[%0d] dout=%0d expected=%0d timeout=%0b", j, got, exp, to);
            else pass_cnt++;
        end
    endtask

    task automatic test_extremes();
        logic signed [33:0] got, exp;
        bit to;
        wr_coef(0, -131072);
        for (int k = 1; k < N; k++) wr_coef(k, 0);
        run_sample(-16'sd32768, got, to);
        total_cnt++;
        if (to || got !== 34'sd4294967296) $display("FAIL extreme_min dout=%0d expected=4294967296 timeout=%0b", got, to);
        else pass_cnt++;
        wr_coef(16, 131071);
        for (int j = 0; j < 17; j++) begin
            run_sample(j == 0 ? 16'sd32767 : (j == 16 ? -16'sd32768 : 16'sd0), got, to);
            exp = model_out();
            total_cnt++;
            if (to || got !== exp) $display("FAIL extreme_seq[%0d] dout=%0d expected=%0d timeout=%0b", j, got, exp, to);
            else pass_cnt++;
        end
    endtask

    task automatic test_timing();
        logic signed [15:0] x, first_din;
        logic signed [33:0] exp;
        int ce_n, rl, vo_at, clr_bad;
        x = 16'($urandom);
        ce_n = 0;
        rl = 0;
        vo_at = -1;
        clr_bad = 0;
        first_din = '0;
        din = x;
        val_in = 1'b1;
        for (int i = 0; i <= 21; i++) begin
            @(posedge clk);
            #1 val_in = 1'b0;
            if (i == 0) first_din = mac_din;
            if (mac_ce) ce_n++;
            if (!ready) rl++;
            if (val_out && vo_at < 0) vo_at = i;
            if (mac_clr !== (i >= N + 1)) clr_bad++;
        end
        hist.push_front(longint'(x));
        exp = model_out();
        total_cnt++;
        if (ce_n != N) $display("FAIL timing_ce got=%0d expected=%0d", ce_n, N);
        else pass_cnt++;
        total_cnt++;
        if (vo_at != N + 1) $display("FAIL timing_valout got=%0d expected=%0d", vo_at, N + 1);
        else pass_cnt++;
        total_cnt++;
        if (rl != N + 2) $display("FAIL timing_ready got=%0d expected=%0d", rl, N + 2);
        else pass_cnt++;
        total_cnt++;
        if (clr_bad != 0) $display("FAIL timing_clr got=%0d expected=0", clr_bad);
        else pass_cnt++;
        total_cnt++;
        if (first_din !== x) $display("FAIL timing_tap0 got=%0d expected=%0d", first_din, x);
        else pass_cnt++;
        total_cnt++;
        if (dout !== exp) $display("FAIL timing_dout got=%0d expected=%0d", dout, exp);
        else pass_cnt++;
    endtask

    task automatic test_coef_fwd();
        logic signed [15:0] x;
        logic signed [17:0] cv, seen;
        logic signed [33:0] got, exp;
        bit to;
        x = 16'($urandom);
        cv = 18'($urandom);
        wr_coef(20, 1234);
        din = x;
        val_in = 1'b1;
        coef_addr = 5'd0;
        coef_wdata = cv;
        coef_we = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        coef_we = 1'b0;
        seen = mac_coef;
        mc[0] = longint'(cv);
        hist.push_front(longint'(x));
        to = 1'b1;
        got = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (val_out) begin
                got = dout;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        exp = model_out();
        total_cnt++;
        if (seen !== cv) $display("FAIL coef_fwd_tap0 got=%0d expected=%0d", seen, cv);
        else pass_cnt++;
        total_cnt++;
        if (to || got !== exp) $display("FAIL coef_fwd dout=%0d expected=%0d timeout=%0b", got, exp, to);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic signed [33:0] got, exp;
        logic signed [17:0] r;
        bit to;
        for (int j = 0; j < 30; j++) begin
            r = 18'($urandom);
            wr_coef(int'($urandom_range(0, 31)), longint'(r));
            run_sample(16'($urandom), got, to);
            exp = model_out();
            total_cnt++;
            if (to || got !== exp) $display("FAIL random[%0d] dout=%0d expected=%0d timeout=%0b", j, got, exp, to);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_drop();
        logic signed [33:0] got, exp;
        bit to;
        int v0;
        do_reset();
        for (int k = 0; k < N; k++) wr_coef(k, longint'($urandom_range(1, 1000)));
        wr_coef(3, -5);
        for (int j = 0; j < 5; j++) run_sample(16'($urandom_range(1, 30000)), got, to);
        total_cnt++;
        if (ovf !== 1'b0) $display("FAIL busy_ovf_pre got=%b expected=0", ovf);
        else pass_cnt++;
        v0 = vo_cnt;
        din = 16'sd1000;
        val_in = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        hist.push_front(1000);
        repeat (5) @(posedge clk);
        #1 din = 16'sd99;
        val_in = 1'b1;
        coef_addr = 5'd3;
        coef_wdata = 18'sd777;
        coef_we = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        coef_we = 1'b0;
        to = 1'b1;
        got = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (val_out) begin
                got = dout;
                to = 1'b0;
                break;
            end
        end
        repeat (25) @(posedge clk);
        #1;
        exp = model_out();
        total_cnt++;
        if (to || got !== exp) $display("FAIL busy_dout dout=%0d expected=%0d timeout=%0b", got, exp, to);
        else pass_cnt++;
        total_cnt++;
        if (ovf !== 1'b1) $display("FAIL busy_ovf got=%b expected=1", ovf);
        else pass_cnt++;
        total_cnt++;
        if (vo_cnt - v0 != 1) $display("FAIL busy_valcount got=%0d expected=1", vo_cnt - v0);
        else pass_cnt++;
        run_sample(16'sd7, got, to);
        exp = model_out();
        total_cnt++;
        if (to || got !== exp) $display("FAIL busy_coef_kept dout=%0d expected=%0d timeout=%0b", got, exp, to);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic signed [33:0] got, exp;
        bit to;
        int v0;
        do_reset();
        for (int k = 0; k < N; k++) wr_coef(k, longint'($urandom_range(1, 500)));
        run_sample(16'sd300, got, to);
        v0 = vo_cnt;
        din = 16'sd400;
        val_in = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        hist.push_front(400);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (val_out) break;
        end
        din = 16'sd55;
        val_in = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        total_cnt++;
        if (ovf !== 1'b1) $display("FAIL b2b_ovf got=%b expected=1", ovf);
        else pass_cnt++;
        repeat (25) @(posedge clk);
        #1;
        total_cnt++;
        if (vo_cnt - v0 != 1) $display("FAIL b2b_valcount got=%0d expected=1", vo_cnt - v0);
        else pass_cnt++;
        run_sample(16'sd9, got, to);
        exp = model_out();
        total_cnt++;
        if (to || got !== exp) $display("FAIL b2b_next dout=%0d expected=%0d timeout=%0b", got, exp, to);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int v0;
        for (int k = 0; k < N; k++) wr_coef(k, 50 + k);
        din = 16'sd5;
        val_in = 1'b1;
        @(posedge clk);
        #1 val_in = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({mac_ce, mac_clr, val_out, ready} !== 4'b0101)
            $display("FAIL midrst_async got=%b expected=0101", {mac_ce, mac_clr, val_out, ready});
        else pass_cnt++;
        v0 = vo_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        repeat (25) @(posedge clk);
        #1;
        total_cnt++;
        if (vo_cnt != v0) $display("FAIL midrst_no_valout got=%0d expected=0", vo_cnt - v0);
        else pass_cnt++;
        test_impulse("midrst_impulse");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_impulse("impulse");
        test_step();
        test_timing();
        test_extremes();
        test_coef_fwd();
        test_random();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
